game_flow_ctrl: RTL and testbench

Game-flow sequencer for the Pac-Man design. It consumes the per-frame collision and bean-cleared results and the player start request, then owns the round life cycle: ready countdown, play, death animation, lives bookkeeping, game over and win. It drives the run enable for the pacman/ghost movers, a respawn pulse that returns the characters to their start positions, and the status flags used by the display and the scoreboard.

---
 rtl/game_flow_ctrl.sv | 119 +++++++++++
 tb/tb_game_flow_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Pac-Man round sequencer: ready countdown, play, death animation, lives,
// game over and win, with mover run enable and a one-clk respawn pulse.
module game_flow_ctrl #(
  parameter int LIVES       = 3,
  parameter int READY_TICKS = 180,
  parameter int DEATH_TICKS = 120,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  input  logic       cleared,
  output logic       run,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       blink,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TICKS - 1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_TICKS - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  state_t           cur_state, nxt_state;
  logic [1:0]       lives_q, nxt_lives;
  logic [CNT_W-1:0] cnt_q, nxt_cnt;
  logic             start_d;
  logic             respawn_q, nxt_respawn;
  logic             start_rise;

  assign start_rise = start & ~start_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state <= IDLE;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      start_d   <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      lives_q   <= nxt_lives;
      cnt_q     <= nxt_cnt;
      start_d   <= start;
      respawn_q <= nxt_respawn;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_lives = lives_q;
    nxt_cnt   = cnt_q;
    case (cur_state)
      IDLE, OVER, WIN: begin
        if (start_rise) begin
          nxt_state = READY;
          nxt_lives = LIVES_INIT;
          nxt_cnt   = '0;
        end
      end
      READY: begin
        if (frame_tick) begin
          if (cnt_q == READY_LAST) begin
            nxt_state = PLAY;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        // Clearing the board outranks a collision in the same cycle.
        if (cleared) begin
          nxt_state = WIN;
        end else if (crash) begin
          nxt_state = DYING;
          nxt_cnt   = '0;
          nxt_lives = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (cnt_q == DEATH_LAST) begin
            nxt_cnt   = '0;
            nxt_state = (lives_q == 2'd0) ? OVER : READY;
          end else begin
            nxt_cnt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Every entry into READY comes from another state, so the pulse marks it.
  assign nxt_respawn = (nxt_state == READY) && (cur_state != READY);

  assign run       = (cur_state == PLAY);
  assign game_over = (cur_state == OVER);
  assign win       = (cur_state == WIN);
  assign blink     = (cur_state == DYING) & cnt_q[3];
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign state     = cur_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with short ready/death
// countdowns so whole rounds fit in a few hundred clocks.
module tb_game_flow_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       crash;
  logic       cleared;
  logic       run;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] state;
  logic       blink;
  logic       game_over;
  logic       win;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int resp_base;

  game_flow_ctrl #(
    .LIVES(3),
    .READY_TICKS(4),
    .DEATH_TICKS(16),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start(start),
    .crash(crash),
    .cleared(cleared),
    .run(run),
    .respawn(respawn),
    .lives(lives),
    .state(state),
    .blink(blink),
    .game_over(game_over),
    .win(win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (respawn) resp_cnt++;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one input pattern for n clocks, then returns all inputs to 0.
  task automatic applyStimulus(input logic s, input logic c, input logic cl,
                               input logic ft, input int n);
    start = s; crash = c; cleared = cl; frame_tick = ft;
    stepClk(n);
    start = 1'b0; crash = 1'b0; cleared = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
      stepClk(1);
    end
  endtask

  task automatic dieOnce();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    frameTicks(16);
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; crash = 1'b0; cleared = 1'b0;
    stepClk(2);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_lives", lives, 3);
    checkOutput("reset_run", run, 0);
    checkOutput("reset_respawn", respawn, 0);
    checkOutput("reset_game_over", game_over, 0);
    checkOutput("reset_win", win, 0);
    rst = 1'b1;
    stepClk(1);

    resp_base = resp_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    stepClk(1);
    checkOutput("held_start_pulses", resp_cnt - resp_base, 1);
    checkOutput("held_start_state", state, 1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("ready_ignores_crash_lives", lives, 3);
    checkOutput("ready_ignores_crash_state", state, 1);
    frameTicks(3);
    checkOutput("ready_3_ticks", state, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("ready_4th_tick_state", state, 2);
    checkOutput("play_run", run, 1);
    frameTicks(2);
    checkOutput("play_ignores_tick", state, 2);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("crash_state", state, 3);
    checkOutput("crash_lives", lives, 2);
    checkOutput("crash_run", run, 0);
    frameTicks(7);
    checkOutput("blink_7_ticks", blink, 0);
    frameTicks(1);
    checkOutput("blink_8_ticks", blink, 1);
    resp_base = resp_cnt;
    frameTicks(7);
    checkOutput("dying_15_ticks", state, 3);
    frameTicks(1);
    checkOutput("death_done_state", state, 1);
    checkOutput("death_done_respawn", resp_cnt - resp_base, 1);
    checkOutput("death_done_blink", blink, 0);

    frameTicks(4);
    dieOnce();
    checkOutput("second_death_lives", lives, 1);
    checkOutput("second_death_state", state, 1);
    frameTicks(4);
    resp_base = resp_cnt;
    dieOnce();
    checkOutput("third_death_lives", lives, 0);
    checkOutput("over_state", state, 4);
    checkOutput("over_flag", game_over, 1);
    checkOutput("over_no_respawn", resp_cnt - resp_base, 0);

    resp_base = resp_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("restart_state", state, 1);
    checkOutput("restart_lives", lives, 3);
    checkOutput("restart_respawn", respawn, 1);
    stepClk(1);
    checkOutput("restart_respawn_count", resp_cnt - resp_base, 1);

    frameTicks(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("cleared_beats_crash_state", state, 5);
    checkOutput("win_flag", win, 1);
    checkOutput("win_lives", lives, 3);
    checkOutput("win_run", run, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("win_restart_state", state, 1);
    frameTicks(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    frameTicks(9);
    checkOutput("pre_reset_blink", blink, 1);
    rst = 1'b0;
    stepClk(1);
    rst = 1'b1;
    checkOutput("mid_dying_reset_state", state, 0);
    checkOutput("mid_dying_reset_lives", lives, 3);
    checkOutput("mid_dying_reset_blink", blink, 0);
    checkOutput("mid_dying_reset_respawn", respawn, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("idle_crash_lives", lives, 3);
    checkOutput("idle_crash_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
